spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_clk_div.sv | 24 ++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and command payload for the SPI register master.
package spi_pkg;

  localparam int unsigned ADDR_W          = 7;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BIT_CNT_W       = 5;
  localparam int unsigned SHIFT_W         = 1 + ADDR_W + DATA_W;
  localparam int unsigned FRAME_BITS      = 17;
  localparam int unsigned TAIL_PULSES     = 3;
  localparam int unsigned DATA_START_EDGE = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_TAIL  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  localparam logic [ADDR_W-1:0] REG_ADDR_0 = 7'd0;
  localparam logic [ADDR_W-1:0] REG_ADDR_1 = 7'd1;
  localparam logic [ADDR_W-1:0] REG_ADDR_2 = 7'd2;
  localparam logic [ADDR_W-1:0] REG_ADDR_3 = 7'd3;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } spi_cmd_t;

  // Bits shifted out after the dummy bit; reads carry an all-zero data field.
  function automatic logic [SHIFT_W-1:0] build_frame(spi_cmd_t cmd);
    return {cmd.rw, cmd.addr, (cmd.rw ? DATA_W'(0) : cmd.wdata)};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host request/response and SPI pin bundle for spi_master.
interface spi_master_if;
  import spi_pkg::*;

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, cs_n, sclk, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, cs_n, sclk, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles, restarted by clr.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 25000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)               cnt_q <= '0;
    else if (clr || tick_c)   cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// SPI register-access master: 17-bit command frame, 3 trailing cs_n-high pulses, done pulse.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25000
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  logic [2:0]           state_q, state_d;
  logic                 rw_q, rw_d;
  logic [SHIFT_W-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, busy_q, done_q;
  logic                 tick_c;
  spi_cmd_t             cmd_c;

  assign cmd_c = {bus.rw, bus.addr, bus.wdata};

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .tick_c  (tick_c)
  );

  // Next-state and datapath; bit_cnt runs 0..17 in SHIFT and on to 20 in TAIL.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (bus.start) begin
          rw_d    = cmd_c.rw;
          frame_d = build_frame(cmd_c);
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick_c) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_TAIL: begin
        if (tick_c) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
            if (state_q == ST_SHIFT) begin
              mosi_d  = frame_q[SHIFT_W-1];
              frame_d = {frame_q[SHIFT_W-2:0], 1'b0};
              if (rw_q && (bit_cnt_q >= BIT_CNT_W'(DATA_START_EDGE - 1)))
                rx_d = {rx_q[DATA_W-2:0], bus.miso};
            end
          end else if ((state_q == ST_SHIFT) && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS))) begin
            state_d = ST_HOLD;
          end else if ((state_q == ST_TAIL) &&
                       (bit_cnt_q == BIT_CNT_W'(FRAME_BITS + TAIL_PULSES))) begin
            if (rw_q) rdata_d = rx_q;
            state_d = ST_FIN;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          sclk_d  = 1'b1;
          state_d = ST_TAIL;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rw_q      <= 1'b0;
      frame_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
      busy_q    <= (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                   (state_d == ST_HOLD)  || (state_d == ST_TAIL);
      done_q    <= (state_d == ST_FIN);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.cs_n  = cs_n_q;
  assign bus.sclk  = sclk_q;
  assign bus.mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (CLK_DIV=4) with a behavioural register slave.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int LATENCY = 42 * CLK_DIV + 1;

  typedef struct {
    logic [16:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  spi_master_if bus();

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [7:0] model_rdata = 8'h00;
  logic [7:0] exp_regs [4] = '{default: 8'h00};

  // Behavioural slave: shifts on sclk rise while selected, commits on first cs_n-high rise.
  logic [7:0]  regs [4] = '{default: 8'h00};
  logic [16:0] sl_sh = '0;
  int          sl_cnt = 0;
  logic [7:0]  sl_rd = 8'h00;
  logic        sl_rw = 1'b0;
  logic        sl_miso = 1'b0;
  logic        miso_stuck = 1'b0;

  assign bus.miso = miso_stuck ? 1'b1 : sl_miso;

  always @(posedge bus.sclk or negedge bus.cs_n) begin
    if (!bus.cs_n && !bus.sclk) begin
      sl_cnt = 0;
    end else if (!bus.cs_n) begin
      sl_sh = {sl_sh[15:0], bus.mosi};
      sl_cnt++;
      if (sl_cnt == 9) begin
        sl_rw = sl_sh[7];
        sl_rd = (sl_sh[6:0] < 7'd4) ? regs[sl_sh[1:0]] : 8'h00;
      end
      if (sl_cnt >= 10 && sl_cnt <= 17) sl_miso = sl_rw & sl_rd[17 - sl_cnt];
    end else begin
      if (sl_cnt == 17 && !sl_sh[15] && sl_sh[14:8] < 7'd4) regs[sl_sh[9:8]] = sl_sh[7:0];
      sl_cnt = 0;
    end
  end

  // Cumulative monitors; tasks take deltas.
  int          rise_lo = 0;
  int          rise_hi = 0;
  int          done_cnt = 0;
  logic [16:0] mon_frame = '0;

  always @(posedge bus.sclk) begin
    if (!bus.cs_n) begin
      mon_frame = {mon_frame[15:0], bus.mosi};
      rise_lo++;
    end else begin
      rise_hi++;
    end
  end

  always @(negedge sys_clk) if (bus.done) done_cnt++;

  function automatic logic [16:0] exp_frame(logic rw, logic [6:0] addr, logic [7:0] wdata);
    return {1'b0, rw, addr, (rw ? 8'h00 : wdata)};
  endfunction

  task automatic push_exp(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rd_val);
    exp_t e;
    e.frame = exp_frame(rw, addr, wdata);
    if (rw) model_rdata = rd_val;
    e.rdata = model_rdata;
    if (!rw && addr < 7'd4) exp_regs[addr[1:0]] = wdata;
    sb_q.push_back(e);
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                         input bit hammer, output int lat, output logic [16:0] frame,
                         output int lo, output int hi, output int dones);
    int lo0, hi0, d0;
    lo0 = rise_lo; hi0 = rise_hi; d0 = done_cnt;
    @(negedge sys_clk);
    bus.rw = rw; bus.addr = addr; bus.wdata = wdata; bus.start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge sys_clk);
      if (bus.done) begin
        lat = c;
        break;
      end
      bus.start = hammer ? ~bus.start : 1'b0;
      if (hammer) begin
        bus.rw    = 1'($urandom);
        bus.addr  = 7'($urandom);
        bus.wdata = 8'($urandom);
      end
    end
    bus.start = 1'b0;
    repeat (4) @(negedge sys_clk);
    frame = mon_frame;
    lo    = rise_lo - lo0;
    hi    = rise_hi - hi0;
    dones = done_cnt - d0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_tests++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", bus.cs_n); end
    n_tests++; if (bus.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", bus.sclk); end
    n_tests++; if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", bus.mosi); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", bus.rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_write;
    exp_t e; int lat, lo, hi, dn; logic [16:0] fr;
    push_exp(1'b0, 7'h02, 8'hA5, 8'h00);
    run_txn(1'b0, 7'h02, 8'hA5, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL write_frame got %b want %b", fr, e.frame); end
    n_tests++; if (fr !== 17'b0_0_0000010_10100101) begin n_fail++; $display("FAIL write_frame_lit got %b", fr); end
    n_tests++; if (lat != LATENCY) begin n_fail++; $display("FAIL write_latency got %0d want %0d", lat, LATENCY); end
    n_tests++; if (lo != FRAME_BITS) begin n_fail++; $display("FAIL write_cs_low_pulses got %0d want %0d", lo, FRAME_BITS); end
    n_tests++; if (hi != TAIL_PULSES) begin n_fail++; $display("FAIL write_tail_pulses got %0d want %0d", hi, TAIL_PULSES); end
    n_tests++; if (dn != 1) begin n_fail++; $display("FAIL write_done_count got %0d want 1", dn); end
    n_tests++; if (regs[2] !== exp_regs[2]) begin n_fail++; $display("FAIL write_reg2 got %h want %h", regs[2], exp_regs[2]); end
    n_tests++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL write_rdata got %h want %h", bus.rdata, e.rdata); end
  endtask

  task automatic test_write_read;
    exp_t e; int lat, lo, hi, dn; logic [16:0] fr;
    push_exp(1'b0, REG_ADDR_1, 8'h3C, 8'h00);
    run_txn(1'b0, REG_ADDR_1, 8'h3C, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (lat != LATENCY) begin n_fail++; $display("FAIL wr_latency got %0d want %0d", lat, LATENCY); end
    n_tests++; if (regs[1] !== 8'h3C) begin n_fail++; $display("FAIL wr_reg1 got %h want 3c", regs[1]); end
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL wr_frame got %b want %b", fr, e.frame); end
    push_exp(1'b1, REG_ADDR_1, 8'h99, 8'h3C);
    run_txn(1'b1, REG_ADDR_1, 8'h99, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (lat != LATENCY) begin n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, LATENCY); end
    n_tests++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL rd_rdata got %h want %h", bus.rdata, e.rdata); end
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL rd_frame got %b want %b", fr, e.frame); end
    n_tests++; if (regs[1] !== 8'h3C) begin n_fail++; $display("FAIL rd_reg1_kept got %h want 3c", regs[1]); end
  endtask

  task automatic test_bad_addr;
    exp_t e; int lat, lo, hi, dn; logic [16:0] fr;
    push_exp(1'b0, 7'h05, 8'hFF, 8'h00);
    run_txn(1'b0, 7'h05, 8'hFF, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (dn != 1) begin n_fail++; $display("FAIL bad_addr_done got %0d want 1", dn); end
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL bad_addr_frame got %b want %b", fr, e.frame); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (regs[i] !== exp_regs[i]) begin
        n_fail++; $display("FAIL bad_addr_reg%0d got %h want %h", i, regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat, lo, hi, dn; logic [16:0] fr;
    push_exp(1'b0, REG_ADDR_3, 8'h5A, 8'h00);
    run_txn(1'b0, REG_ADDR_3, 8'h5A, 1'b1, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (lo + hi != 20) begin n_fail++; $display("FAIL b2b_pulses got %0d want 20", lo + hi); end
    n_tests++; if (dn != 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", dn); end
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL b2b_frame got %b want %b", fr, e.frame); end
    n_tests++; if (regs[3] !== exp_regs[3]) begin n_fail++; $display("FAIL b2b_reg3 got %h want %h", regs[3], exp_regs[3]); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy); end
    push_exp(1'b0, REG_ADDR_0, 8'h77, 8'h00);
    run_txn(1'b0, REG_ADDR_0, 8'h77, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (lat != LATENCY) begin n_fail++; $display("FAIL b2b_next_latency got %0d want %0d", lat, LATENCY); end
    n_tests++; if (regs[0] !== exp_regs[0]) begin n_fail++; $display("FAIL b2b_reg0 got %h want %h", regs[0], exp_regs[0]); end
  endtask

  task automatic test_reset_mid;
    exp_t e; int lat, lo, hi, dn, lo0, d0; logic [16:0] fr; bit seen;
    lo0 = rise_lo; d0 = done_cnt; seen = 1'b0;
    @(negedge sys_clk);
    bus.rw = 1'b0; bus.addr = REG_ADDR_1; bus.wdata = 8'hEE; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (rise_lo - lo0 >= 9) begin seen = 1'b1; break; end
      @(negedge sys_clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL abort_ninth_edge got %0d edges want 9", rise_lo - lo0); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n got %b want 1", bus.cs_n); end
    n_tests++; if (bus.sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk got %b want 0", bus.sclk); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    n_tests++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
    n_tests++; if (regs[1] !== exp_regs[1]) begin n_fail++; $display("FAIL abort_reg1 got %h want %h", regs[1], exp_regs[1]); end
    model_rdata = 8'h00;
    push_exp(1'b0, REG_ADDR_0, 8'h11, 8'h00);
    run_txn(1'b0, REG_ADDR_0, 8'h11, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (regs[0] !== 8'h11) begin n_fail++; $display("FAIL post_reset_reg0 got %h want 11", regs[0]); end
    n_tests++; if (fr !== e.frame) begin n_fail++; $display("FAIL post_reset_frame got %b want %b", fr, e.frame); end
    n_tests++; if (lat != LATENCY) begin n_fail++; $display("FAIL post_reset_latency got %0d want %0d", lat, LATENCY); end
    n_tests++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL post_reset_rdata got %h want %h", bus.rdata, e.rdata); end
  endtask

  task automatic test_miso_stuck;
    exp_t e; int lat, lo, hi, dn; logic [16:0] fr;
    miso_stuck = 1'b1;
    push_exp(1'b1, REG_ADDR_2, 8'h00, 8'hFF);
    run_txn(1'b1, REG_ADDR_2, 8'h00, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    miso_stuck = 1'b0;
    n_tests++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL stuck_rdata got %h want %h", bus.rdata, e.rdata); end
    push_exp(1'b0, REG_ADDR_3, 8'h42, 8'h00);
    run_txn(1'b0, REG_ADDR_3, 8'h42, 1'b0, lat, fr, lo, hi, dn);
    e = sb_q.pop_front();
    n_tests++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL stuck_hold_rdata got %h want %h", bus.rdata, e.rdata); end
    n_tests++; if (regs[3] !== exp_regs[3]) begin n_fail++; $display("FAIL stuck_reg3 got %h want %h", regs[3], exp_regs[3]); end
    n_tests++; if (dn != 1) begin n_fail++; $display("FAIL stuck_done got %0d want 1", dn); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_read();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid();
    test_miso_stuck();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
